bp_me_cache_pkt_throttle: RTL

//  Sits between the CCE-to-cache converter's cache_pkt_o and the bsg_cache

---
 rtl/bp_me_cache_pkt_throttle.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bp_me_cache_pkt_throttle.sv
//==============================================================================
// Module      : bp_me_cache_pkt_throttle
// Description : Registered 2/4-entry cache packet buffer with an outstanding-
//               request credit cap; the response path passes straight through.
//               Optional perf counters: BP_ME_CACHE_PKT_THROTTLE_PERF_EN
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bp_me_cache_pkt_throttle #(
  parameter int pkt_width_p       = 64,
  parameter int data_width_p      = 64,
  parameter int max_outstanding_p = 4,
  parameter int els_p             = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [pkt_width_p-1:0]  cache_pkt_i,
  input  logic                    cache_pkt_v_i,
  output logic                    cache_pkt_ready_o,
  output logic [pkt_width_p-1:0]  cache_pkt_o,
  output logic                    cache_pkt_v_o,
  input  logic                    cache_pkt_ready_i,
  input  logic [data_width_p-1:0] cache_data_i,
  input  logic                    cache_v_i,
  output logic                    cache_yumi_o,
  output logic [data_width_p-1:0] data_o,
  output logic                    v_o,
  input  logic                    yumi_i
);

  localparam int c_ptr_w = $clog2(els_p);
  localparam int c_occ_w = $clog2(els_p + 1);
  localparam int c_cnt_w = $clog2(max_outstanding_p + 1);

  logic [pkt_width_p-1:0] mem_q [els_p];
  logic [c_ptr_w-1:0]     rptr_q, rptr_d;
  logic [c_ptr_w-1:0]     wptr_q, wptr_d;
  logic [c_occ_w-1:0]     occ_q, occ_d;
  logic [c_cnt_w-1:0]     cnt_q, cnt_d;

  logic w_full, w_empty, w_credit, w_enq, w_issue, w_retire;

  assign w_full   = (occ_q == c_occ_w'(els_p));
  assign w_empty  = (occ_q == '0);
  assign w_credit = (cnt_q < c_cnt_w'(max_outstanding_p));

  // Ready comes only from registered occupancy, so a same-cycle dequeue never frees a slot.
  assign cache_pkt_ready_o = ~w_full & ~reset_i;
  assign cache_pkt_v_o     = ~w_empty & w_credit & ~reset_i;
  assign cache_pkt_o       = reset_i ? '0 : mem_q[rptr_q];

  assign data_o       = reset_i ? '0 : cache_data_i;
  assign v_o          = cache_v_i & ~reset_i;
  assign cache_yumi_o = yumi_i & ~reset_i;

  assign w_enq    = cache_pkt_v_i & cache_pkt_ready_o;
  assign w_issue  = cache_pkt_v_o & cache_pkt_ready_i;
  assign w_retire = v_o & yumi_i;

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    occ_d  = occ_q;
    cnt_d  = cnt_q;
    if (w_issue) rptr_d = rptr_q + c_ptr_w'(1);
    if (w_enq)   wptr_d = wptr_q + c_ptr_w'(1);
    case ({w_enq, w_issue})
      2'b10:   occ_d = occ_q + c_occ_w'(1);
      2'b01:   occ_d = occ_q - c_occ_w'(1);
      default: occ_d = occ_q;
    endcase
    case ({w_issue, w_retire})
      2'b10:   cnt_d = cnt_q + c_cnt_w'(1);
      2'b01:   cnt_d = cnt_q - c_cnt_w'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      occ_q  <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      occ_q  <= occ_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) mem_q[wptr_q] <= cache_pkt_i;
  end

`ifdef BP_ME_CACHE_PKT_THROTTLE_PERF_EN
  logic [31:0] stall_credit_r, stall_credit_d;
  logic [31:0] stall_cache_r, stall_cache_d;
  logic [31:0] issued_r, issued_d;

  always_comb begin
    stall_credit_d = stall_credit_r;
    stall_cache_d  = stall_cache_r;
    issued_d       = issued_r;
    if (~w_empty & ~w_credit & (stall_credit_r != '1))
      stall_credit_d = stall_credit_r + 32'd1;
    if (cache_pkt_v_o & ~cache_pkt_ready_i & (stall_cache_r != '1))
      stall_cache_d = stall_cache_r + 32'd1;
    if (w_issue & (issued_r != '1))
      issued_d = issued_r + 32'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_credit_r <= '0;
      stall_cache_r  <= '0;
      issued_r       <= '0;
    end else begin
      stall_credit_r <= stall_credit_d;
      stall_cache_r  <= stall_cache_d;
      issued_r       <= issued_d;
    end
  end
`else
  // Counters are absent in this build; ports and timing are unchanged.
`endif

endmodule

`default_nettype wire
